// File: rtl/mem_refill_ctrl.sv
// Cache block refill controller: fetches one block word by word from memory, streams
// each word to the cache, and aborts with fill_err if memory stops answering.
module mem_refill_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss_req,
    input  logic [ADDR_WIDTH-1:0]         miss_addr,
    output logic                          req_ready,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic                          mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]         mem_rd_data,
    output logic                          fill_valid,
    output logic [$clog2(BLOCK_SIZE/(DATA_WIDTH/8))-1:0] fill_idx,
    output logic [DATA_WIDTH-1:0]         fill_data,
    output logic                          fill_done,
    output logic                          fill_err
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int WORDS   = BLOCK_SIZE / BYTES;
    localparam int WORD_W  = $clog2(WORDS);
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int TO_W    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [TO_W-1:0]       tcnt_q, tcnt_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  fvalid_q, fvalid_d;
    logic [WORD_W-1:0]     fidx_q, fidx_d;
    logic [DATA_WIDTH-1:0] fdata_q, fdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  load_addr;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        word_d    = word_q;
        tcnt_d    = tcnt_q;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        fvalid_d  = 1'b0;
        fidx_d    = fidx_q;
        fdata_d   = fdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        load_addr = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    base_d    = miss_addr & ~ADDR_WIDTH'(BLOCK_SIZE - 1);
                    word_d    = '0;
                    load_addr = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response in the final allowed cycle still wins over the timeout.
                if (mem_rd_valid) begin
                    fvalid_d = 1'b1;
                    fidx_d   = word_q;
                    fdata_d  = mem_rd_data;
                    if (word_q == WORD_W'(WORDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        word_d    = word_q + 1'b1;
                        load_addr = 1'b1;
                        state_d   = ISSUE;
                    end
                end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobe and address are registered on entry to ISSUE so they are valid during it.
        if (load_addr) begin
            rd_en_d = 1'b1;
            addr_d  = base_d + (ADDR_WIDTH'(word_d) << BYTE_SH);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            word_q   <= '0;
            tcnt_q   <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            fvalid_q <= 1'b0;
            fidx_q   <= '0;
            fdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            word_q   <= word_d;
            tcnt_q   <= tcnt_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            fvalid_q <= fvalid_d;
            fidx_q   <= fidx_d;
            fdata_q  <= fdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_rd_en  = rd_en_q;
    assign mem_addr   = addr_q;
    assign fill_valid = fvalid_q;
    assign fill_idx   = fidx_q;
    assign fill_data  = fdata_q;
    assign fill_done  = done_q;
    assign fill_err   = err_q;

endmodule

// File: doc/mem_refill_ctrl.md
MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 Parameter BLOCK_SIZE, default 16, cache block size in bytes; WORDS = BLOCK_SIZE/(DATA_WIDTH/8), default 4.
REQ-004 Parameter TIMEOUT, default 15, max cycles waiting for one memory response.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous reset, active-low.
REQ-007 miss_req  input  1  cache miss refill request.
REQ-008 miss_addr  input  ADDR_WIDTH  missing byte address.
REQ-009 req_ready  output  1  high when a request can be accepted.
REQ-010 mem_rd_en  output  1  one-cycle memory read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  memory word byte address.
REQ-012 mem_rd_valid  input  1  memory response valid.
REQ-013 mem_rd_data  input  DATA_WIDTH  memory response data.
REQ-014 fill_valid  output  1  one-cycle pulse, fill word valid toward cache.
REQ-015 fill_idx  output  $clog2(WORDS)  word index within block.
REQ-016 fill_data  output  DATA_WIDTH  fill word.
REQ-017 fill_done  output  1  one-cycle pulse, block complete.
REQ-018 fill_err  output  1  one-cycle pulse, refill aborted on timeout.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; req_ready SHALL equal (state==IDLE).
REQ-020 In IDLE, miss_req=1 SHALL latch block base = miss_addr with low $clog2(BLOCK_SIZE) bits zeroed, clear word counter, go to ISSUE next cycle.
REQ-021 miss_req while not IDLE SHALL be ignored (no queueing, no state change).
REQ-022 In ISSUE: mem_rd_en=1 for exactly one cycle, mem_addr = base + word*(DATA_WIDTH/8) modulo 2^ADDR_WIDTH, timeout counter cleared, go to WAIT.
REQ-023 mem_addr SHALL hold its last value outside ISSUE; mem_rd_en=0 in all other states.
REQ-024 In WAIT, mem_rd_valid=1 SHALL register fill_valid=1, fill_idx=word, fill_data=mem_rd_data on the next cycle (one-cycle latency).
REQ-025 On that response: if word==WORDS-1 go to DONE, else word+1 and go to ISSUE.
REQ-026 mem_rd_valid outside WAIT SHALL be ignored.
REQ-027 In WAIT, timeout counter SHALL increment each cycle without mem_rd_valid; on reaching TIMEOUT, fill_err pulses one cycle and state returns to IDLE without fill_done.
REQ-028 mem_rd_valid in the same cycle the counter reaches TIMEOUT SHALL count as a response (no error).
REQ-029 DONE SHALL last exactly one cycle with fill_done=1, then IDLE.
REQ-030 Minimum refill latency, acceptance to fill_done, SHALL be 2*WORDS+1 cycles at zero memory wait.
REQ-031 fill_valid, fill_done, fill_err SHALL be mutually exclusive single-cycle pulses, otherwise 0.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force IDLE; word and timeout counters 0; mem_rd_en, fill_valid, fill_done, fill_err 0; mem_addr, fill_idx, fill_data 0; req_ready 1 after reset release.
REQ-033 Reset mid-refill SHALL abort silently (no fill_done, no fill_err); responses arriving afterwards SHALL be ignored.

Verification
REQ-034 miss_addr=0x123, memory responds 1 cycle after each strobe -> mem_addr 0x120,0x124,0x128,0x12C; fill_idx 0..3 with matching data; fill_done once.
REQ-035 miss_addr=0x7FC (top block) -> base 0x7F0, mem_addr 0x7F0..0x7FC, no wrap error, fill_done once.
REQ-036 miss_req held high during refill with a different address -> ignored; next refill starts only after DONE, req_ready low throughout busy period.
REQ-037 No mem_rd_valid for 15 cycles after second strobe -> fill_err pulse, no fill_done, req_ready 1 next cycle; valid on the 15th cycle instead -> normal completion.
REQ-038 rst_n low during WAIT of word 2, then late mem_rd_valid -> all outputs 0, state IDLE, no fill_valid/fill_done.
REQ-039 Back-to-back misses 0x040 then 0x200 with miss_req re-asserted on return to IDLE -> two complete fills, correct addresses, each fill_done exactly once.
